// File: rtl/thunder_time_monitor.sv
// thunder_time_monitor
// Consumes decoded timing packets from the thunderbolt receiver, range-checks
// them, tracks TOW continuity and runs the UNLOCKED / ACQUIRING / LOCKED /
// HOLDOVER qualification state machine. Holds the latest valid GPS time.
module thunder_time_monitor #(
    parameter int unsigned CLK_FREQ_HZ = 10_000_000,
    parameter int unsigned TIMEOUT_S   = 2,
    parameter int unsigned HOLDOVER_S  = 10,
    parameter int unsigned LOCK_COUNT  = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_thunder_packet_dv,
    input  logic [88:0] i_thunder_data,
    output logic        o_time_dv,
    output logic [31:0] o_tow,
    output logic [15:0] o_week,
    output logic [15:0] o_utc_offset,
    output logic [7:0]  o_timing_flags,
    output logic [4:0]  o_hour,
    output logic [5:0]  o_min,
    output logic [5:0]  o_sec,
    output logic [1:0]  o_state,
    output logic        o_locked,
    output logic [15:0] o_err_count
);

    localparam int unsigned TIMEOUT_CYC  = CLK_FREQ_HZ * TIMEOUT_S;
    localparam int unsigned HOLDOVER_CYC = CLK_FREQ_HZ * HOLDOVER_S;
    localparam int unsigned TIMER_MAX    = (TIMEOUT_CYC > HOLDOVER_CYC) ? TIMEOUT_CYC : HOLDOVER_CYC;
    localparam int          TW           = $clog2(TIMER_MAX + 1);
    localparam int          CW           = $clog2(LOCK_COUNT + 1);

    localparam logic [TW-1:0] TIMEOUT_RELOAD  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] HOLDOVER_RELOAD = TW'(HOLDOVER_CYC - 1);
    localparam logic [CW-1:0] LOCK_TARGET     = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] CNT_ONE         = CW'(1);
    localparam logic [31:0]   TOW_LAST        = 32'd604799;
    localparam logic [31:0]   TOW_LIMIT       = 32'd604800;

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_ACQUIRING = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_HOLDOVER  = 2'd3
    } state_t;

    // Incoming packet field decode
    logic [31:0] w_inTow;
    logic [15:0] w_inWeek;
    logic [5:0]  w_inSec;
    logic [5:0]  w_inMin;
    logic [4:0]  w_inHour;
    logic        w_inRangeOk;

    assign w_inTow     = i_thunder_data[88:57];
    assign w_inWeek    = i_thunder_data[56:41];
    assign w_inSec     = i_thunder_data[16:11];
    assign w_inMin     = i_thunder_data[10:5];
    assign w_inHour    = i_thunder_data[4:0];
    assign w_inRangeOk = (w_inTow < TOW_LIMIT) && (w_inWeek != 16'd0) &&
                         (w_inSec <= 6'd59) && (w_inMin <= 6'd59) && (w_inHour <= 5'd23);

    // Stage-1 registers
    logic        r_s1Valid;
    logic [88:0] r_s1Data;
    logic        r_s1RangeOk;

    // Stage-1 field views
    logic [31:0] w_s1Tow;
    logic [15:0] w_s1Week;
    logic [15:0] w_s1Utc;
    logic [7:0]  w_s1Flags;
    logic [5:0]  w_s1Sec;
    logic [5:0]  w_s1Min;
    logic [4:0]  w_s1Hour;

    assign w_s1Tow   = r_s1Data[88:57];
    assign w_s1Week  = r_s1Data[56:41];
    assign w_s1Utc   = r_s1Data[40:25];
    assign w_s1Flags = r_s1Data[24:17];
    assign w_s1Sec   = r_s1Data[16:11];
    assign w_s1Min   = r_s1Data[10:5];
    assign w_s1Hour  = r_s1Data[4:0];

    // Stage-2 state
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_errCount;

    assign o_state     = r_state;
    assign o_err_count = r_errCount;

    // Continuity against the last valid time held on the outputs
    logic [31:0] w_towInc;
    logic [15:0] w_weekInc;
    logic        w_contOk;
    logic        w_timerZero;
    logic        w_expired;
    logic [CW-1:0] w_cntInc;

    assign w_towInc    = o_tow + 32'd1;
    assign w_weekInc   = o_week + 16'd1;
    assign w_contOk    = ((w_s1Tow == w_towInc) && (w_s1Week == o_week)) ||
                         ((o_tow == TOW_LAST) && (w_s1Tow == 32'd0) && (w_s1Week == w_weekInc));
    assign w_timerZero = (r_timer == '0);
    assign w_expired   = !r_s1Valid && w_timerZero && (r_state != ST_UNLOCKED);
    assign w_cntInc    = r_cnt + CNT_ONE;

    // Next state, good-packet count, timer and error strobe
    state_t        w_nextState;
    logic [CW-1:0] w_nextCnt;
    logic [TW-1:0] w_nextTimer;
    logic          w_errInc;

    // Capture each strobed packet together with its range verdict
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1Valid   <= 1'b0;
            r_s1Data    <= '0;
            r_s1RangeOk <= 1'b0;
        end else begin
            r_s1Valid <= i_thunder_packet_dv;
            if (i_thunder_packet_dv) begin
                r_s1Data    <= i_thunder_data;
                r_s1RangeOk <= w_inRangeOk;
            end
        end
    end

    // Decide the qualification transition; a packet always beats a timer expiry
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_errInc    = 1'b0;
        if (r_state == ST_UNLOCKED) begin
            w_nextTimer = '0;
        end else if (!w_timerZero) begin
            w_nextTimer = r_timer - 1'b1;
        end else begin
            w_nextTimer = r_timer;
        end

        if (r_s1Valid) begin
            w_nextTimer = TIMEOUT_RELOAD;
            w_errInc    = !r_s1RangeOk;
            case (r_state)
                ST_UNLOCKED: begin
                    if (r_s1RangeOk) begin
                        w_nextState = ST_ACQUIRING;
                        w_nextCnt   = CNT_ONE;
                    end
                end
                ST_ACQUIRING: begin
                    if (r_s1RangeOk && w_contOk) begin
                        w_nextCnt = w_cntInc;
                        if (w_cntInc >= LOCK_TARGET) begin
                            w_nextState = ST_LOCKED;
                        end
                    end else if (r_s1RangeOk) begin
                        w_nextCnt = CNT_ONE;
                        w_errInc  = 1'b1;
                    end else begin
                        w_nextState = ST_UNLOCKED;
                        w_nextCnt   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (r_s1RangeOk && !w_contOk) begin
                        w_nextState = ST_ACQUIRING;
                        w_nextCnt   = CNT_ONE;
                        w_errInc    = 1'b1;
                    end else if (!r_s1RangeOk) begin
                        w_nextState = ST_HOLDOVER;
                        w_nextTimer = HOLDOVER_RELOAD;
                    end
                end
                ST_HOLDOVER: begin
                    if (r_s1RangeOk) begin
                        w_nextState = ST_ACQUIRING;
                        w_nextCnt   = CNT_ONE;
                    end
                end
                default: w_nextState = ST_UNLOCKED;
            endcase
        end else if (w_expired) begin
            case (r_state)
                ST_LOCKED: begin
                    w_nextState = ST_HOLDOVER;
                    w_nextTimer = HOLDOVER_RELOAD;
                end
                default: begin
                    w_nextState = ST_UNLOCKED;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    // Register state, timer, saturating error count and the held time outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_UNLOCKED;
            r_cnt          <= '0;
            r_timer        <= '0;
            r_errCount     <= 16'd0;
            o_locked       <= 1'b0;
            o_time_dv      <= 1'b0;
            o_tow          <= 32'd0;
            o_week         <= 16'd0;
            o_utc_offset   <= 16'd0;
            o_timing_flags <= 8'd0;
            o_hour         <= 5'd0;
            o_min          <= 6'd0;
            o_sec          <= 6'd0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_timer   <= w_nextTimer;
            o_locked  <= (w_nextState == ST_LOCKED);
            o_time_dv <= r_s1Valid && r_s1RangeOk;
            if (w_errInc && (r_errCount != 16'hFFFF)) begin
                r_errCount <= r_errCount + 16'd1;
            end
            if (r_s1Valid && r_s1RangeOk) begin
                o_tow          <= w_s1Tow;
                o_week         <= w_s1Week;
                o_utc_offset   <= w_s1Utc;
                o_timing_flags <= w_s1Flags;
                o_hour         <= w_s1Hour;
                o_min          <= w_s1Min;
                o_sec          <= w_s1Sec;
            end
        end
    end

endmodule

// File: tb/tb_thunder_time_monitor.sv
// tb_thunder_time_monitor
// Table of packets with hand-computed expected state/error/tow, a scoreboard
// queue for o_time_dv content and latency, and hand-written sequences for
// timeouts, expiry collision, reset, back-to-back packets and saturation.
module tb_thunder_time_monitor;

    typedef struct {
        logic [31:0] tow;
        logic [15:0] week;
        logic [15:0] utc;
        logic [7:0]  flags;
        logic [5:0]  sec;
        logic [5:0]  min;
        logic [4:0]  hour;
        bit          expDv;
        logic [1:0]  expState;
        logic [15:0] expErr;
        logic [31:0] expTow;
    } vec_t;

    typedef struct {
        logic [88:0] data;
        int          cycle;
    } exp_t;

    localparam logic [15:0] WK  = 16'd2200;
    localparam logic [15:0] WK1 = 16'd2201;
    localparam logic [4:0]  HH  = 5'd12;
    localparam logic [5:0]  MM  = 6'd34;
    localparam logic [5:0]  SS  = 6'd56;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dvIn = 1'b0;
    logic [88:0] dataIn = '0;
    logic        o_time_dv;
    logic [31:0] o_tow;
    logic [15:0] o_week;
    logic [15:0] o_utc_offset;
    logic [7:0]  o_timing_flags;
    logic [4:0]  o_hour;
    logic [5:0]  o_min;
    logic [5:0]  o_sec;
    logic [1:0]  o_state;
    logic        o_locked;
    logic [15:0] o_err_count;

    int   nChecks = 0;
    int   nFails = 0;
    int   cyc = 0;
    exp_t scoreQ[$];
    exp_t expHead;
    vec_t vecs[26];

    thunder_time_monitor #(
        .CLK_FREQ_HZ(1000),
        .TIMEOUT_S(2),
        .HOLDOVER_S(10),
        .LOCK_COUNT(3)
    ) dut (
        .i_clk(clock),
        .i_rst(reset),
        .i_thunder_packet_dv(dvIn),
        .i_thunder_data(dataIn),
        .o_time_dv(o_time_dv),
        .o_tow(o_tow),
        .o_week(o_week),
        .o_utc_offset(o_utc_offset),
        .o_timing_flags(o_timing_flags),
        .o_hour(o_hour),
        .o_min(o_min),
        .o_sec(o_sec),
        .o_state(o_state),
        .o_locked(o_locked),
        .o_err_count(o_err_count)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Cycle counter used for latency and timeout bookkeeping
    always @(posedge clock) cyc <= cyc + 1;

    function automatic vec_t makeVec(input logic [31:0] tow, input logic [15:0] week,
                                     input logic [4:0] hour, input logic [5:0] min,
                                     input logic [5:0] sec, input bit expDv,
                                     input logic [1:0] expState, input logic [15:0] expErr,
                                     input logic [31:0] expTow);
        vec_t v;
        v.tow = tow; v.week = week; v.utc = 16'hFFEE; v.flags = tow[7:0] ^ 8'h5A;
        v.sec = sec; v.min = min; v.hour = hour;
        v.expDv = expDv; v.expState = expState; v.expErr = expErr; v.expTow = expTow;
        return v;
    endfunction

    function automatic logic [88:0] packData(input vec_t v);
        return {v.tow, v.week, v.utc, v.flags, v.sec, v.min, v.hour};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one packet strobe at the current negedge and queue its expected output
    task automatic driveOnly(input vec_t v, output int s2Cyc);
        exp_t e;
        dataIn = packData(v);
        dvIn   = 1'b1;
        s2Cyc  = cyc + 2;
        if (v.expDv) begin
            e.data  = packData(v);
            e.cycle = cyc + 2;
            scoreQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input vec_t v, output int s2Cyc);
        driveOnly(v, s2Cyc);
        @(negedge clock);
        dvIn = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Scoreboard: every o_time_dv must match the oldest queued packet and its cycle
    always @(negedge clock) begin
        if (!reset && o_time_dv) begin
            nChecks++;
            if (scoreQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL timeDv: unexpected pulse at cycle %0d tow %0d, none expected", cyc, o_tow);
            end else begin
                expHead = scoreQ.pop_front();
                if ({o_tow, o_week, o_utc_offset, o_timing_flags, o_sec, o_min, o_hour} !== expHead.data ||
                    cyc != expHead.cycle) begin
                    nFails++;
                    $display("[TB] FAIL timeDv: got tow %0d week %0d at cycle %0d, expected tow %0d week %0d at cycle %0d",
                             o_tow, o_week, cyc, expHead.data[88:57], expHead.data[56:41], expHead.cycle);
                end
            end
        end
    end

    // Watchdog so the bench always terminates
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s2;
        int lastS2;
        logic [1:0]  stressState[4];
        logic [15:0] satErr[3];
        vec_t v;

        vecs[0]  = makeVec(32'd100,    WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd0, 32'd100);
        vecs[1]  = makeVec(32'd101,    WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd0, 32'd101);
        vecs[2]  = makeVec(32'd102,    WK,    HH,    MM,    SS,    1'b1, 2'd2, 16'd0, 32'd102);
        vecs[3]  = makeVec(32'd103,    WK,    HH,    MM,    6'd60, 1'b0, 2'd3, 16'd1, 32'd102);
        vecs[4]  = makeVec(32'd200,    WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd1, 32'd200);
        vecs[5]  = makeVec(32'd201,    WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd1, 32'd201);
        vecs[6]  = makeVec(32'd202,    WK,    HH,    MM,    SS,    1'b1, 2'd2, 16'd1, 32'd202);
        vecs[7]  = makeVec(32'd300,    WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd2, 32'd300);
        vecs[8]  = makeVec(32'd301,    WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd2, 32'd301);
        vecs[9]  = makeVec(32'd302,    WK,    HH,    MM,    SS,    1'b1, 2'd2, 16'd2, 32'd302);
        vecs[10] = makeVec(32'd604797, WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd3, 32'd604797);
        vecs[11] = makeVec(32'd604798, WK,    HH,    MM,    SS,    1'b1, 2'd1, 16'd3, 32'd604798);
        vecs[12] = makeVec(32'd604799, WK,    HH,    MM,    SS,    1'b1, 2'd2, 16'd3, 32'd604799);
        vecs[13] = makeVec(32'd0,      WK1,   HH,    MM,    SS,    1'b1, 2'd2, 16'd3, 32'd0);
        vecs[14] = makeVec(32'd5,      WK1,   HH,    MM,    SS,    1'b1, 2'd1, 16'd4, 32'd5);
        vecs[15] = makeVec(32'd6,      WK1,   5'd23, 6'd59, 6'd59, 1'b1, 2'd1, 16'd4, 32'd6);
        vecs[16] = makeVec(32'd7,      WK1,   HH,    MM,    SS,    1'b1, 2'd2, 16'd4, 32'd7);
        vecs[17] = makeVec(32'd8,      16'd0, HH,    MM,    SS,    1'b0, 2'd3, 16'd5, 32'd7);
        vecs[18] = makeVec(32'd50,     WK1,   HH,    MM,    SS,    1'b1, 2'd1, 16'd5, 32'd50);
        vecs[19] = makeVec(32'd604800, WK1,   HH,    MM,    SS,    1'b0, 2'd0, 16'd6, 32'd50);
        vecs[20] = makeVec(32'd51,     WK1,   5'd24, MM,    SS,    1'b0, 2'd0, 16'd7, 32'd50);
        vecs[21] = makeVec(32'd51,     WK1,   HH,    MM,    SS,    1'b1, 2'd1, 16'd7, 32'd51);
        vecs[22] = makeVec(32'd52,     WK1,   HH,    6'd60, SS,    1'b0, 2'd0, 16'd8, 32'd51);
        vecs[23] = makeVec(32'd52,     WK1,   HH,    MM,    SS,    1'b1, 2'd1, 16'd8, 32'd52);
        vecs[24] = makeVec(32'd53,     WK1,   HH,    MM,    SS,    1'b1, 2'd1, 16'd8, 32'd53);
        vecs[25] = makeVec(32'd54,     WK1,   HH,    MM,    SS,    1'b1, 2'd2, 16'd8, 32'd54);

        // Reset values
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("resetState",  32'(o_state), 32'd0);
        checkOutput("resetLocked", 32'(o_locked), 32'd0);
        checkOutput("resetTow",    o_tow, 32'd0);
        checkOutput("resetWeek",   32'(o_week), 32'd0);
        checkOutput("resetErr",    32'(o_err_count), 32'd0);
        checkOutput("resetTimeDv", 32'(o_time_dv), 32'd0);

        // Table-driven packets at ~1000-cycle spacing
        lastS2 = 0;
        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i], lastS2);
            repeat (3) @(negedge clock);
            checkOutput($sformatf("vec%0d.state", i),  32'(o_state), 32'(vecs[i].expState));
            checkOutput($sformatf("vec%0d.locked", i), 32'(o_locked), (vecs[i].expState == 2'd2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("vec%0d.err", i),    32'(o_err_count), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d.tow", i),    o_tow, vecs[i].expTow);
            checkOutput($sformatf("vec%0d.pending", i), 32'(scoreQ.size()), 32'd0);
            repeat (1000) @(negedge clock);
        end

        // LOCKED -> HOLDOVER after 2000 idle cycles, then UNLOCKED 10000 later
        waitUntil(lastS2 + 1999);
        checkOutput("toBeforeExpiry", 32'(o_state), 32'd2);
        @(negedge clock);
        checkOutput("toHoldover",     32'(o_state), 32'd3);
        checkOutput("toHoldoverLock", 32'(o_locked), 32'd0);
        waitUntil(lastS2 + 11999);
        checkOutput("hoBeforeExpiry", 32'(o_state), 32'd3);
        @(negedge clock);
        checkOutput("hoUnlocked",     32'(o_state), 32'd0);

        // Relock, then land a packet on the exact expiry cycle
        for (int i = 0; i < 3; i++) begin
            v = makeVec(32'(1000 + i), WK1, HH, MM, SS, 1'b1, 2'd0, 16'd8, 32'd0);
            applyStimulus(v, lastS2);
            repeat (500) @(negedge clock);
        end
        checkOutput("relockState", 32'(o_state), 32'd2);
        waitUntil(lastS2 + 1998);
        v = makeVec(32'd1003, WK1, HH, MM, SS, 1'b1, 2'd2, 16'd8, 32'd1003);
        applyStimulus(v, s2);
        waitUntil(lastS2 + 2000);
        checkOutput("collisionState", 32'(o_state), 32'd2);
        checkOutput("collisionTow",   o_tow, 32'd1003);
        waitUntil(lastS2 + 3999);
        checkOutput("collisionReload", 32'(o_state), 32'd2);
        @(negedge clock);
        checkOutput("collisionExpire", 32'(o_state), 32'd3);
        checkOutput("collisionErr",    32'(o_err_count), 32'd8);

        // Asynchronous reset with a packet sitting in stage 1
        v = makeVec(32'd2000, WK1, HH, MM, SS, 1'b0, 2'd0, 16'd0, 32'd0);
        driveOnly(v, s2);
        @(posedge clock);
        #2;
        reset = 1'b1;
        dvIn  = 1'b0;
        #1;
        checkOutput("asyncState",  32'(o_state), 32'd0);
        checkOutput("asyncTow",    o_tow, 32'd0);
        checkOutput("asyncWeek",   32'(o_week), 32'd0);
        checkOutput("asyncErr",    32'(o_err_count), 32'd0);
        checkOutput("asyncFlags",  32'(o_timing_flags), 32'd0);
        checkOutput("asyncUtc",    32'(o_utc_offset), 32'd0);
        checkOutput("asyncHour",   32'(o_hour), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("flushTow",   o_tow, 32'd0);
        checkOutput("flushState", 32'(o_state), 32'd0);

        // Back-to-back packets on four consecutive cycles
        stressState[0] = 2'd1; stressState[1] = 2'd1; stressState[2] = 2'd2; stressState[3] = 2'd2;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                v = makeVec(32'(10 + i), WK, HH, MM, SS, 1'b1, 2'd0, 16'd0, 32'd0);
                driveOnly(v, s2);
            end else begin
                dvIn = 1'b0;
            end
            if (i >= 2) checkOutput($sformatf("stress%0d.state", i - 2), 32'(o_state), 32'(stressState[i - 2]));
            @(negedge clock);
        end
        repeat (2) @(negedge clock);
        checkOutput("stressTow",     o_tow, 32'd13);
        checkOutput("stressPending", 32'(scoreQ.size()), 32'd0);

        // Error counter saturation
        force dut.r_errCount = 16'hFFFD;
        @(negedge clock);
        release dut.r_errCount;
        @(negedge clock);
        satErr[0] = 16'hFFFE; satErr[1] = 16'hFFFF; satErr[2] = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                v = makeVec(32'(14 + i), WK, HH, MM, 6'd60, 1'b0, 2'd0, 16'd0, 32'd0);
                driveOnly(v, s2);
            end else begin
                dvIn = 1'b0;
            end
            if (i >= 2) checkOutput($sformatf("sat%0d.err", i - 2), 32'(o_err_count), 32'(satErr[i - 2]));
            @(negedge clock);
        end
        checkOutput("satState", 32'(o_state), 32'd3);
        checkOutput("satTow",   o_tow, 32'd13);
        repeat (3) @(negedge clock);
        checkOutput("finalPending", 32'(scoreQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
